floo_vc_router_switch_locked: RTL and testbench

- Registered NxN crossbar for the VC router, placed between switch allocation and the output links.
- Carries two header fields: the output VC id and the lookahead direction.
- Generalises the combinational switch in three ways: a parametrised connectivity mask instead of a hard-coded XY pattern, per-output wormhole locking across multi-flit packets, and an optional output pipeline register.
- Flags grant protocol violations per output.

---
 rtl/floo_vc_router_switch_locked_if.sv | 39 +++
 rtl/floo_vc_router_switch_locked.sv | 176 +++++++++++++++++
 tb/tb_floo_vc_router_switch_locked.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/floo_vc_router_switch_locked_if.sv
// Bundle between switch allocation and the locked VC-router crossbar.
// Headers travel as flat HdrWidth vectors; the crossbar owns the field layout.
interface floo_vc_router_switch_locked_if #(
  parameter int unsigned NumPorts   = 5,
  parameter int unsigned NumVCMax   = 4,
  parameter int unsigned NumVCWidth = 2,
  parameter int unsigned HdrWidth   = 21,
  parameter int unsigned DataLength = 16,
  parameter int unsigned DirWidth   = 3
);
  localparam int unsigned FlitWidth = HdrWidth + DataLength;

  logic [NumPorts-1:0]                               valid_i;
  logic [NumPorts-1:0][NumVCMax-1:0][DataLength-1:0] vc_data_head_i;
  logic [NumPorts-1:0][HdrWidth-1:0]                 ctrl_head_per_inport_i;
  logic [NumPorts-1:0][NumVCMax-1:0]                 read_vc_id_oh_i;
  logic [NumPorts-1:0][NumPorts-1:0]                 inport_id_oh_per_output_i;
  logic [NumPorts-1:0][NumVCWidth-1:0]               vc_assignment_id_i;
  logic [NumPorts-1:0][DirWidth-1:0]                 look_ahead_routing_sel_i;
  logic [NumPorts-1:0]                               last_bits_sel_i;
  logic [NumPorts-1:0]                               valid_o;
  logic [NumPorts-1:0][FlitWidth-1:0]                data_o;
  logic [NumPorts-1:0]                               locked_o;
  logic [NumPorts-1:0]                               err_o;

  modport master (
    output valid_i, vc_data_head_i, ctrl_head_per_inport_i, read_vc_id_oh_i,
           inport_id_oh_per_output_i, vc_assignment_id_i, look_ahead_routing_sel_i,
           last_bits_sel_i,
    input  valid_o, data_o, locked_o, err_o
  );

  modport slave (
    input  valid_i, vc_data_head_i, ctrl_head_per_inport_i, read_vc_id_oh_i,
           inport_id_oh_per_output_i, vc_assignment_id_i, look_ahead_routing_sel_i,
           last_bits_sel_i,
    output valid_o, data_o, locked_o, err_o
  );
endinterface

// File: rtl/floo_vc_router_switch_locked.sv
// NxN VC-router crossbar with per-output wormhole locking, connectivity mask,
// grant protocol checking and an optional output register.
//
// state  | meaning
// Idle   | output free; the next forwarded flit is treated as a packet head
// Locked | output owned by in_q until a flit with last=1 passes
module floo_vc_router_switch_locked #(
  parameter int unsigned NumPorts                     = 5,
  parameter int unsigned NumVC [NumPorts]             = '{2, 4, 2, 4, 4},
  parameter int unsigned NumVCMax                     = 4,
  parameter int unsigned NumVCWidth                   = 2,
  parameter logic [NumPorts-1:0][NumPorts-1:0] ConnMask =
    {5'h0F, 5'h17, 5'h1B, 5'h1D, 5'h1E},
  parameter bit          OutReg                       = 1'b1,
  parameter int unsigned DataLength                   = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  floo_vc_router_switch_locked_if.slave sw
);
  localparam int unsigned InWidth = (NumPorts > 1) ? $clog2(NumPorts) : 1;
  localparam logic [NumPorts-1:0] GrantOne = {{(NumPorts-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {DirN, DirE, DirS, DirW, DirL0} route_direction_e;

  typedef struct packed {
    logic                  rob_req;
    logic [1:0]            rob_idx;
    logic [3:0]            dst_id;
    logic [3:0]            src_id;
    logic                  last;
    logic                  atop;
    logic [2:0]            axi_ch;
    logic [NumVCWidth-1:0] vc_id;
    route_direction_e      lookahead;
  } hdr_t;

  typedef struct packed {
    hdr_t                  hdr;
    logic [DataLength-1:0] payload;
  } flit_t;

  typedef enum logic {Idle, Locked} lock_state_e;

  logic [NumPorts-1:0][DataLength-1:0] payload_sel;
  flit_t [NumPorts-1:0]                flit;
  logic [NumPorts-1:0]                 fwd, err, locked;
  lock_state_e [NumPorts-1:0]          state_q, state_d;
  logic [NumPorts-1:0][InWidth-1:0]    in_q, in_d;
  logic [NumPorts-1:0][NumVCWidth-1:0] vc_q, vc_d;

  // VCs beyond an inport's real VC count never contribute to its payload.
  always_comb begin
    for (int unsigned i = 0; i < NumPorts; i++) begin
      payload_sel[i] = '0;
      for (int unsigned v = 0; v < NumVCMax; v++) begin
        if ((v < NumVC[i]) && sw.read_vc_id_oh_i[i][v]) begin
          payload_sel[i] |= sw.vc_data_head_i[i][v];
        end
      end
    end
  end

  always_comb begin
    logic [NumPorts-1:0] grant;
    logic [InWidth-1:0]  in_idx;
    logic                one_hot, legal, lock_ok;
    hdr_t                hdr;
    grant   = '0;
    in_idx  = '0;
    one_hot = 1'b0;
    legal   = 1'b0;
    lock_ok = 1'b0;
    hdr     = '0;
    state_d = state_q;
    in_d    = in_q;
    vc_d    = vc_q;
    fwd     = '0;
    err     = '0;
    flit    = '0;
    for (int unsigned o = 0; o < NumPorts; o++) begin
      grant  = sw.inport_id_oh_per_output_i[o];
      in_idx = '0;
      for (int unsigned i = 0; i < NumPorts; i++) begin
        if (grant[i]) in_idx = InWidth'(i);
      end
      one_hot = (grant != '0) && ((grant & (grant - GrantOne)) == '0);
      legal   = |(grant & ConnMask[o] & sw.valid_i);
      lock_ok = (state_q[o] == Idle) || (in_idx == in_q[o]);
      fwd[o]  = one_hot && legal && lock_ok;
      err[o]  = (grant != '0) && !fwd[o];

      hdr           = hdr_t'(sw.ctrl_head_per_inport_i[in_idx]);
      hdr.lookahead = route_direction_e'(sw.look_ahead_routing_sel_i[o]);
      hdr.last      = sw.last_bits_sel_i[o];
      // Body flits keep the VC chosen for the head, whatever VC allocation says now.
      hdr.vc_id     = (state_q[o] == Locked) ? vc_q[o] : sw.vc_assignment_id_i[o];
      flit[o].hdr     = hdr;
      flit[o].payload = payload_sel[in_idx];

      if (fwd[o]) begin
        if (state_q[o] == Idle) begin
          if (!sw.last_bits_sel_i[o]) begin
            state_d[o] = Locked;
            in_d[o]    = in_idx;
            vc_d[o]    = sw.vc_assignment_id_i[o];
          end
        end else if (sw.last_bits_sel_i[o]) begin
          state_d[o] = Idle;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned o = 0; o < NumPorts; o++) state_q[o] <= Idle;
      in_q <= '0;
      vc_q <= '0;
    end else begin
      state_q <= state_d;
      in_q    <= in_d;
      vc_q    <= vc_d;
    end
  end

  always_comb begin
    locked = '0;
    for (int unsigned o = 0; o < NumPorts; o++) locked[o] = (state_q[o] == Locked);
  end

  assign sw.locked_o = locked;

  if (OutReg) begin : g_out_reg
    logic [NumPorts-1:0]  valid_q, valid_d, err_q, err_d;
    flit_t [NumPorts-1:0] data_q, data_d;

    always_comb begin
      valid_d = fwd;
      err_d   = err;
      data_d  = data_q;
      for (int unsigned o = 0; o < NumPorts; o++) begin
        if (fwd[o]) data_d[o] = flit[o];
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        valid_q <= '0;
        err_q   <= '0;
        data_q  <= '0;
      end else begin
        valid_q <= valid_d;
        err_q   <= err_d;
        data_q  <= data_d;
      end
    end

    assign sw.valid_o = valid_q;
    assign sw.err_o   = err_q;
    assign sw.data_o  = data_q;
  end else begin : g_out_comb
    flit_t [NumPorts-1:0] data_masked;

    always_comb begin
      data_masked = '0;
      for (int unsigned o = 0; o < NumPorts; o++) begin
        if (fwd[o]) data_masked[o] = flit[o];
      end
    end

    assign sw.valid_o = fwd;
    assign sw.err_o   = err;
    assign sw.data_o  = data_masked;
  end
endmodule

// File: tb/tb_floo_vc_router_switch_locked.sv
// Bench: registered and combinational switch instances share one stimulus;
// directed scenarios plus a randomized run against a packet-level reference model.
module tb_floo_vc_router_switch_locked;
  localparam int NP  = 5;
  localparam int NVM = 4;
  localparam int NVW = 2;
  localparam int HW  = 21;
  localparam int DL  = 16;
  localparam int FW  = HW + DL;
  localparam int unsigned NUM_VC [NP] = '{2, 4, 2, 4, 4};
  // Default mask (no U-turns) with output E additionally refusing inport N.
  localparam logic [NP-1:0][NP-1:0] MASK = {5'h0F, 5'h17, 5'h1B, 5'h1C, 5'h1E};
  localparam int N = 0, E = 1, S = 2, W = 3, L0 = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NP-1:0]                valid_i;
  logic [NP-1:0][NVM-1:0][DL-1:0] vc_data;
  logic [NP-1:0][HW-1:0]        ctrl;
  logic [NP-1:0][NVM-1:0]       read_oh;
  logic [NP-1:0][NP-1:0]        grant;
  logic [NP-1:0][NVW-1:0]       vc_assign;
  logic [NP-1:0][2:0]           look_ahead;
  logic [NP-1:0]                last_sel;

  int vectors = 0;
  int errors  = 0;

  floo_vc_router_switch_locked_if #(.NumPorts(NP), .NumVCMax(NVM), .NumVCWidth(NVW),
    .HdrWidth(HW), .DataLength(DL), .DirWidth(3)) bus_r ();
  floo_vc_router_switch_locked_if #(.NumPorts(NP), .NumVCMax(NVM), .NumVCWidth(NVW),
    .HdrWidth(HW), .DataLength(DL), .DirWidth(3)) bus_c ();

  assign bus_r.valid_i = valid_i;
  assign bus_r.vc_data_head_i = vc_data;
  assign bus_r.ctrl_head_per_inport_i = ctrl;
  assign bus_r.read_vc_id_oh_i = read_oh;
  assign bus_r.inport_id_oh_per_output_i = grant;
  assign bus_r.vc_assignment_id_i = vc_assign;
  assign bus_r.look_ahead_routing_sel_i = look_ahead;
  assign bus_r.last_bits_sel_i = last_sel;
  assign bus_c.valid_i = valid_i;
  assign bus_c.vc_data_head_i = vc_data;
  assign bus_c.ctrl_head_per_inport_i = ctrl;
  assign bus_c.read_vc_id_oh_i = read_oh;
  assign bus_c.inport_id_oh_per_output_i = grant;
  assign bus_c.vc_assignment_id_i = vc_assign;
  assign bus_c.look_ahead_routing_sel_i = look_ahead;
  assign bus_c.last_bits_sel_i = last_sel;

  floo_vc_router_switch_locked #(.NumPorts(NP), .NumVC(NUM_VC), .NumVCMax(NVM),
    .NumVCWidth(NVW), .ConnMask(MASK), .OutReg(1'b1), .DataLength(DL)) dut_r (
    .clk_i(clk), .rst_ni(rst_n), .sw(bus_r));

  floo_vc_router_switch_locked #(.NumPorts(NP), .NumVC(NUM_VC), .NumVCMax(NVM),
    .NumVCWidth(NVW), .ConnMask(MASK), .OutReg(1'b0), .DataLength(DL)) dut_c (
    .clk_i(clk), .rst_ni(rst_n), .sw(bus_c));

  // Expected flit: header fields from the inport, routing fields from the output.
  function automatic logic [FW-1:0] exp_flit(int in, int o, logic [NVW-1:0] vc);
    logic [DL-1:0] pl = '0;
    logic [HW-1:0] c  = ctrl[in];
    for (int v = 0; v < NVM; v++)
      if (v < int'(NUM_VC[in]) && read_oh[in][v]) pl = pl | vc_data[in][v];
    return {c[20:10], last_sel[o], c[8:5], vc, look_ahead[o], pl};
  endfunction

  task automatic clear_inputs();
    valid_i = '0; grant = '0; last_sel = '0; vc_assign = '0;
  endtask

  task automatic randomize_payload();
    for (int i = 0; i < NP; i++) begin
      for (int v = 0; v < NVM; v++) vc_data[i][v] = DL'($urandom);
      ctrl[i]       = HW'($urandom);
      read_oh[i]    = NVM'(1 << $urandom_range(0, NVM - 1));
      look_ahead[i] = 3'($urandom_range(0, 4));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (bus_r.valid_o !== 5'b0) begin errors++; $display("FAIL reset_valid: got %b want 00000", bus_r.valid_o); end
    vectors++; if (bus_r.data_o !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", bus_r.data_o); end
    vectors++; if (bus_r.locked_o !== 5'b0) begin errors++; $display("FAIL reset_locked: got %b want 00000", bus_r.locked_o); end
    vectors++; if (bus_r.err_o !== 5'b0) begin errors++; $display("FAIL reset_err: got %b want 00000", bus_r.err_o); end
    vectors++; if (bus_c.locked_o !== 5'b0 || bus_c.err_o !== 5'b0 || bus_c.valid_o !== 5'b0) begin
      errors++; $display("FAIL reset_comb: locked %b err %b valid %b want all 0", bus_c.locked_o, bus_c.err_o, bus_c.valid_o); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_flit();
    logic [FW-1:0] exp;
    logic [DL-1:0] pl = '0;
    clear_inputs(); randomize_payload();
    valid_i[E] = 1'b1; grant[L0] = 5'b00010; last_sel[L0] = 1'b1; vc_assign[L0] = 2'd2;
    exp = exp_flit(E, L0, 2'd2);
    for (int v = 0; v < NVM; v++) if (read_oh[E][v]) pl = vc_data[E][v];
    #1;
    vectors++; if (bus_c.valid_o !== 5'b10000 || bus_c.data_o[L0] !== exp) begin
      errors++; $display("FAIL single_comb: valid %b data %h want 10000 %h", bus_c.valid_o, bus_c.data_o[L0], exp); end
    tick();
    vectors++; if (bus_r.valid_o !== 5'b10000) begin errors++; $display("FAIL single_valid: got %b want 10000", bus_r.valid_o); end
    vectors++; if (bus_r.data_o[L0] !== exp) begin errors++; $display("FAIL single_data: got %h want %h", bus_r.data_o[L0], exp); end
    vectors++; if (bus_r.data_o[L0][DL+4:DL+3] !== 2'd2) begin errors++; $display("FAIL single_vc: got %0d want 2", bus_r.data_o[L0][DL+4:DL+3]); end
    vectors++; if (bus_r.data_o[L0][DL-1:0] !== pl) begin errors++; $display("FAIL single_payload: got %h want %h", bus_r.data_o[L0][DL-1:0], pl); end
    vectors++; if (bus_r.locked_o !== 5'b0) begin errors++; $display("FAIL single_locked: got %b want 00000", bus_r.locked_o); end
    clear_inputs();
    #1;
    vectors++; if (bus_c.data_o !== '0 || bus_c.valid_o !== 5'b0) begin errors++; $display("FAIL single_comb_idle: data %h valid %b want 0", bus_c.data_o, bus_c.valid_o); end
    tick();
    vectors++; if (bus_r.valid_o !== 5'b0 || bus_r.data_o[L0] !== exp) begin
      errors++; $display("FAIL single_hold: valid %b data %h want 00000 %h", bus_r.valid_o, bus_r.data_o[L0], exp); end
  endtask

  task automatic test_wormhole();
    logic [FW-1:0] exp;
    for (int k = 0; k < 4; k++) begin
      clear_inputs(); randomize_payload();
      valid_i[W] = 1'b1; grant[N] = 5'b01000; last_sel[N] = (k == 3);
      vc_assign[N] = (k == 0) ? 2'd1 : 2'd3;
      exp = exp_flit(W, N, 2'd1);
      tick();
      vectors++; if (bus_r.valid_o[N] !== 1'b1 || bus_r.data_o[N] !== exp) begin
        errors++; $display("FAIL worm_flit%0d: valid %b data %h want 1 %h", k, bus_r.valid_o[N], bus_r.data_o[N], exp); end
      vectors++; if (bus_r.locked_o[N] !== (k < 3)) begin
        errors++; $display("FAIL worm_locked%0d: got %b want %b", k, bus_r.locked_o[N], (k < 3)); end
    end
    clear_inputs();
    tick();
    vectors++; if (bus_r.locked_o !== 5'b0 || bus_r.valid_o !== 5'b0) begin
      errors++; $display("FAIL worm_idle: locked %b valid %b want 0", bus_r.locked_o, bus_r.valid_o); end
  endtask

  task automatic test_lock_violation();
    logic [FW-1:0] exp;
    clear_inputs(); randomize_payload();
    valid_i[W] = 1'b1; grant[N] = 5'b01000; vc_assign[N] = 2'd1;
    tick();
    clear_inputs(); randomize_payload();
    valid_i[E] = 1'b1; valid_i[W] = 1'b1; grant[N] = 5'b00010;
    #1;
    vectors++; if (bus_c.err_o !== 5'b00001 || bus_c.valid_o[N] !== 1'b0) begin
      errors++; $display("FAIL lockviol_comb: err %b valid %b want 00001 0", bus_c.err_o, bus_c.valid_o[N]); end
    tick();
    vectors++; if (bus_r.err_o !== 5'b00001) begin errors++; $display("FAIL lockviol_err: got %b want 00001", bus_r.err_o); end
    vectors++; if (bus_r.valid_o[N] !== 1'b0 || bus_r.locked_o[N] !== 1'b1) begin
      errors++; $display("FAIL lockviol_state: valid %b locked %b want 0 1", bus_r.valid_o[N], bus_r.locked_o[N]); end
    clear_inputs();
    tick();
    vectors++; if (bus_r.err_o !== 5'b0) begin errors++; $display("FAIL lockviol_pulse: got %b want 00000", bus_r.err_o); end
    randomize_payload();
    valid_i[W] = 1'b1; grant[N] = 5'b01000; last_sel[N] = 1'b1; vc_assign[N] = 2'd2;
    exp = exp_flit(W, N, 2'd1);
    tick();
    vectors++; if (bus_r.valid_o[N] !== 1'b1 || bus_r.data_o[N] !== exp || bus_r.locked_o[N] !== 1'b0) begin
      errors++; $display("FAIL lockviol_tail: valid %b data %h locked %b want 1 %h 0", bus_r.valid_o[N], bus_r.data_o[N], bus_r.locked_o[N], exp); end
    clear_inputs();
    tick();
  endtask

  task automatic test_protocol_errors();
    int            outs [3];
    logic [NP-1:0] gr [3];
    logic [NP-1:0] vl [3];
    logic [NP-1:0] want;
    outs = '{S, E, W};
    gr   = '{5'b00110, 5'b00001, 5'b10000};
    vl   = '{5'b11111, 5'b00001, 5'b01111};
    for (int c = 0; c < 3; c++) begin
      clear_inputs(); randomize_payload();
      valid_i = vl[c]; grant[outs[c]] = gr[c];
      want = NP'(1 << outs[c]);
      #1;
      vectors++; if (bus_c.err_o !== want || bus_c.valid_o !== 5'b0) begin
        errors++; $display("FAIL proto%0d_comb: err %b valid %b want %b 00000", c, bus_c.err_o, bus_c.valid_o, want); end
      tick();
      vectors++; if (bus_r.err_o !== want || bus_r.valid_o !== 5'b0) begin
        errors++; $display("FAIL proto%0d_reg: err %b valid %b want %b 00000", c, bus_r.err_o, bus_r.valid_o, want); end
      vectors++; if (bus_r.locked_o !== 5'b0) begin errors++; $display("FAIL proto%0d_locked: got %b want 00000", c, bus_r.locked_o); end
      clear_inputs();
      tick();
    end
  endtask

  task automatic test_comb_path();
    logic [FW-1:0] exp;
    clear_inputs(); randomize_payload();
    valid_i[S] = 1'b1; grant[L0] = 5'b00100; last_sel[L0] = 1'b1; vc_assign[L0] = 2'd1;
    exp = exp_flit(S, L0, 2'd1);
    #1;
    vectors++; if (bus_c.valid_o !== 5'b10000 || bus_c.data_o[L0] !== exp) begin
      errors++; $display("FAIL comb_fwd: valid %b data %h want 10000 %h", bus_c.valid_o, bus_c.data_o[L0], exp); end
    clear_inputs();
    #1;
    vectors++; if (bus_c.data_o !== '0 || bus_c.valid_o !== 5'b0) begin
      errors++; $display("FAIL comb_idle: data %h valid %b want 0", bus_c.data_o, bus_c.valid_o); end
    tick();
  endtask

  task automatic test_reset_mid_packet();
    logic [FW-1:0] exp;
    clear_inputs(); randomize_payload();
    valid_i[E] = 1'b1; grant[S] = 5'b00010; vc_assign[S] = 2'd1;
    tick();
    vectors++; if (bus_r.locked_o[S] !== 1'b1 || bus_c.locked_o[S] !== 1'b1) begin
      errors++; $display("FAIL rstmid_head: locked r %b c %b want 1 1", bus_r.locked_o[S], bus_c.locked_o[S]); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (bus_r.valid_o !== 5'b0 || bus_r.data_o !== '0 || bus_r.err_o !== 5'b0) begin
      errors++; $display("FAIL rstmid_out: valid %b err %b data %h want 0", bus_r.valid_o, bus_r.err_o, bus_r.data_o); end
    vectors++; if (bus_r.locked_o !== 5'b0 || bus_c.locked_o !== 5'b0) begin
      errors++; $display("FAIL rstmid_locked: r %b c %b want 00000", bus_r.locked_o, bus_c.locked_o); end
    clear_inputs();
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    randomize_payload();
    valid_i[E] = 1'b1; grant[S] = 5'b00010; vc_assign[S] = 2'd3;
    exp = exp_flit(E, S, 2'd3);
    tick();
    vectors++; if (bus_r.valid_o[S] !== 1'b1 || bus_r.data_o[S] !== exp || bus_r.locked_o[S] !== 1'b1) begin
      errors++; $display("FAIL rstmid_newhead: valid %b data %h locked %b want 1 %h 1", bus_r.valid_o[S], bus_r.data_o[S], bus_r.locked_o[S], exp); end
    randomize_payload();
    last_sel[S] = 1'b1; vc_assign[S] = 2'd0;
    exp = exp_flit(E, S, 2'd3);
    tick();
    vectors++; if (bus_r.data_o[S] !== exp || bus_r.locked_o[S] !== 1'b0) begin
      errors++; $display("FAIL rstmid_tail: data %h locked %b want %h 0", bus_r.data_o[S], bus_r.locked_o[S], exp); end
    clear_inputs();
    tick();
  endtask

  task automatic test_random();
    int               owner [NP];
    logic [NVW-1:0]   owner_vc [NP];
    logic [FW-1:0]    hold [NP];
    int               ein [NP];
    logic [NP-1:0]    ev, ee, el;
    logic [FW-1:0]    ed [NP];
    int               r, in;
    logic             ok;
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    for (int o = 0; o < NP; o++) begin owner[o] = -1; owner_vc[o] = '0; hold[o] = '0; end
    clear_inputs();
    repeat (400) begin
      randomize_payload();
      valid_i = NP'($urandom) | NP'($urandom);
      for (int o = 0; o < NP; o++) begin
        last_sel[o]  = ($urandom_range(0, 2) == 0);
        vc_assign[o] = NVW'($urandom);
        r = $urandom_range(0, 9);
        if (r == 0) grant[o] = '0;
        else if (r == 1) grant[o] = NP'($urandom);
        else if (owner[o] >= 0 && r < 7) grant[o] = NP'(1 << owner[o]);
        else grant[o] = NP'(1 << $urandom_range(0, NP - 1));
      end
      for (int o = 0; o < NP; o++) begin
        in = -1;
        for (int i = 0; i < NP; i++) if (grant[o][i]) in = i;
        ok = 1'b0;
        if ($countones(grant[o]) == 1)
          if (MASK[o][in] && valid_i[in] && (owner[o] < 0 || owner[o] == in)) ok = 1'b1;
        ein[o] = in;
        ev[o]  = ok;
        ee[o]  = (grant[o] != '0) && !ok;
        el[o]  = (owner[o] >= 0);
        ed[o]  = ok ? exp_flit(in, o, (owner[o] >= 0) ? owner_vc[o] : vc_assign[o]) : '0;
      end
      #1;
      vectors++; if (bus_c.valid_o !== ev || bus_c.err_o !== ee || bus_c.locked_o !== el) begin
        errors++; $display("FAIL rand_comb_ctrl: valid %b err %b locked %b want %b %b %b", bus_c.valid_o, bus_c.err_o, bus_c.locked_o, ev, ee, el); end
      for (int o = 0; o < NP; o++) begin
        vectors++; if (bus_c.data_o[o] !== ed[o]) begin
          errors++; $display("FAIL rand_comb_data%0d: got %h want %h", o, bus_c.data_o[o], ed[o]); end
      end
      for (int o = 0; o < NP; o++) begin
        if (ev[o]) begin
          hold[o] = ed[o];
          if (owner[o] < 0 && !last_sel[o]) begin owner[o] = ein[o]; owner_vc[o] = vc_assign[o]; end
          else if (owner[o] >= 0 && last_sel[o]) owner[o] = -1;
        end
        el[o] = (owner[o] >= 0);
      end
      tick();
      vectors++; if (bus_r.valid_o !== ev || bus_r.err_o !== ee) begin
        errors++; $display("FAIL rand_reg_ctrl: valid %b err %b want %b %b", bus_r.valid_o, bus_r.err_o, ev, ee); end
      vectors++; if (bus_r.locked_o !== el || bus_c.locked_o !== el) begin
        errors++; $display("FAIL rand_locked: r %b c %b want %b", bus_r.locked_o, bus_c.locked_o, el); end
      for (int o = 0; o < NP; o++) begin
        vectors++; if (bus_r.data_o[o] !== hold[o]) begin
          errors++; $display("FAIL rand_reg_data%0d: got %h want %h", o, bus_r.data_o[o], hold[o]); end
      end
    end
  endtask

  initial begin
    clear_inputs();
    randomize_payload();
    test_reset();
    test_single_flit();
    test_wormhole();
    test_lock_violation();
    test_protocol_errors();
    test_comb_path();
    test_reset_mid_packet();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
